// File: rtl/dmem_ctrl.sv
// Clocked data memory: valid/ready requests, byte-lane stores, extended loads, fixed response latency.
// Optional DMEM_PERF_CNT_EN adds accepted load/store counters on perf_rd_cnt / perf_wr_cnt.
module dmem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_wr_cnt
);
  localparam int NUM_LANES = 4;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(DEPTH) << 2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  resp_t pend_q, pend_d, resp_q, resp_d, rsp_new;

  logic acc;
  logic [1:0] lane;
  logic [IDX_W-1:0] idx;
  logic misal, oor, err;
  logic [NUM_LANES-1:0] be, lane_we;
  logic [NUM_LANES-1:0][7:0] lane_wdata, lane_rdata;
  logic [31:0] word, ld_data;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  assign acc  = req_valid && req_ready;
  assign lane = req_addr[1:0];
  assign idx  = req_addr[IDX_W+1:2];

  // One byte-wide array per lane; contents survive reset and start at zero.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH] = '{default: 8'h00};
    always_ff @(posedge clk) begin
      if (lane_we[l]) mem[idx] <= lane_wdata[l];
    end
    assign lane_rdata[l] = mem[idx];
  end

  // Request decode, store lane steering and load extraction.
  always_comb begin
    misal = (req_size == 2'b11) ||
            (req_size == 2'b01 && req_addr[0]) ||
            (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    oor   = {1'b0, req_addr} >= ADDR_LIM;
    err   = misal || oor;

    case (req_size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = req_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    lane_we = (acc && req_we && !err) ? be : 4'b0000;

    case (req_size)
      2'b00:   lane_wdata = {4{req_wdata[7:0]}};
      2'b01:   lane_wdata = {2{req_wdata[15:0]}};
      default: lane_wdata = req_wdata;
    endcase

    word     = lane_rdata;
    byte_sel = lane_rdata[lane];
    half_sel = req_addr[1] ? word[31:16] : word[15:0];
    case (req_size)
      2'b00:   ld_data = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   ld_data = {{16{~req_unsigned & half_sel[15]}}, half_sel};
      default: ld_data = word;
    endcase

    rsp_new.err   = err;
    rsp_new.rdata = (err || req_we) ? 32'h0 : ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (acc) begin
          if (LATENCY == 1) state_d = S_RESP;
          else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The result is captured at acceptance and only exposed on entry to RESP,
  // so the response registers stay stable while a request waits.
  always_comb begin
    pend_d = acc ? rsp_new : pend_q;
    resp_d = resp_q;
    if (acc && LATENCY == 1)                          resp_d = rsp_new;
    else if (state_q == S_WAIT && cnt_q == 4'd0)      resp_d = pend_q;
  end

  always_comb begin
    req_ready  = (state_q != S_WAIT);
    resp_valid = (state_q == S_RESP);
    resp_rdata = resp_q.rdata;
    resp_err   = resp_q.err;
  end

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + {31'd0, acc && !req_we};
    wr_cnt_d = wr_cnt_q + {31'd0, acc &&  req_we};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign perf_rd_cnt = rd_cnt_q;
  assign perf_wr_cnt = wr_cnt_q;
`else
  assign perf_rd_cnt = 32'd0;
  assign perf_wr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one LATENCY=1 and one LATENCY=4 instance sharing request wires.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = 32'h0, wdata = 32'h0;

  logic        rdy1, rv1, er1, rdy4, rv4, er4;
  logic [31:0] rd1, rd4, prc1, pwc1, prc4, pwc4;
  logic        rdy, rv, er;
  logic [31:0] rd;

  assign rdy = sel ? rdy4 : rdy1;
  assign rv  = sel ? rv4  : rv1;
  assign rd  = sel ? rd4  : rd1;
  assign er  = sel ? er4  : er1;

  dmem_ctrl #(.DEPTH(256), .ADDR_W(32), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel), .req_ready(rdy1),
    .req_we(we), .req_size(size), .req_unsigned(uns),
    .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1),
    .perf_rd_cnt(prc1), .perf_wr_cnt(pwc1)
  );

  dmem_ctrl #(.DEPTH(256), .ADDR_W(32), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel), .req_ready(rdy4),
    .req_we(we), .req_size(size), .req_unsigned(uns),
    .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv4), .resp_rdata(rd4), .resp_err(er4),
    .perf_rd_cnt(prc4), .perf_wr_cnt(pwc4)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Issue one request, wait for its response and check latency, data and error.
  task automatic req(input bit s, input bit w, input logic [1:0] sz, input bit un,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_d, input bit exp_e, input string tag);
    int n;
    @(negedge clk);
    sel = s; we = w; size = sz; uns = un; addr = a; wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    chk({tag, " accept"}, (n < 50) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rv && n < 50);
    chk({tag, " lat"},  n, s ? 32'd4 : 32'd1);
    chk({tag, " data"}, rd, exp_d);
    chk({tag, " err"},  {31'd0, er}, {31'd0, exp_e});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    logic [31:0] exp_rd, exp_wr;

    repeat (2) @(negedge clk);
    chk("rst ready1", {31'd0, rdy1}, 32'd1);
    chk("rst valid1", {31'd0, rv1},  32'd0);
    chk("rst rdata1", rd1,           32'd0);
    chk("rst err1",   {31'd0, er1},  32'd0);
    chk("rst ready4", {31'd0, rdy4}, 32'd1);
    chk("rst perf",   prc1 | pwc1 | prc4 | pwc4, 32'd0);
    rst_n = 1'b1;

    // LATENCY=1 word round trip and sub-word extraction
    req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, "st w 10");
    @(negedge clk);
    chk("single pulse", {31'd0, rv1}, 32'd0);
    req(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "ld w 10");
    req(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0, "ld hs 12");
    req(0, 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000BEEF, 0, "ld hu 10");
    req(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0, "ld bu 13");
    req(0, 1, 2'b01, 0, 32'h12, 32'hAAAA1234, 32'h0, 0, "st h 12");
    req(0, 0, 2'b10, 1, 32'h10, 32'h0, 32'h1234BEEF, 0, "ld w after h");

    req(0, 1, 2'b00, 0, 32'h21, 32'h00000080, 32'h0, 0, "st b 21");
    req(0, 0, 2'b00, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0, "ld bs 21");
    req(0, 0, 2'b00, 1, 32'h21, 32'h0, 32'h00000080, 0, "ld bu 21");
    req(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h00008000, 0, "ld w 20");

    // Error cases leave memory untouched
    req(0, 1, 2'b10, 0, 32'h0,   32'h11223344, 32'h0, 0, "st w 0");
    req(0, 0, 2'b01, 0, 32'h3,   32'h0, 32'h0, 1, "ld h 3 mis");
    req(0, 1, 2'b10, 0, 32'h2,   32'hFFFFFFFF, 32'h0, 1, "st w 2 mis");
    req(0, 0, 2'b11, 0, 32'h0,   32'h0, 32'h0, 1, "ld size11");
    req(0, 0, 2'b10, 0, 32'h0,   32'h0, 32'h11223344, 0, "ld w 0 kept");
    req(0, 0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1, "ld w 400 oor");
    req(0, 1, 2'b00, 0, 32'h400, 32'h55, 32'h0, 1, "st b 400 oor");
    req(0, 0, 2'b10, 0, 32'h3FC, 32'h0, 32'h0, 0, "ld w 3fc last");

    // LATENCY=4 single request, then back-to-back with acceptance in RESP
    req(1, 1, 2'b10, 0, 32'h40, 32'h12345678, 32'h0, 0, "L4 st w 40");
    @(negedge clk);
    sel = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h40; req_valid = 1'b1;
    chk("b2b ready idle", {31'd0, rdy4}, 32'd1);
    @(posedge clk);
    #1 size = 2'b00; uns = 1'b1; addr = 32'h43;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b ready low A", {31'd0, rdy4}, 32'd0);
      chk("b2b valid low A", {31'd0, rv4},  32'd0);
    end
    @(negedge clk);
    chk("b2b resp A valid", {31'd0, rv4},  32'd1);
    chk("b2b resp A ready", {31'd0, rdy4}, 32'd1);
    chk("b2b resp A data",  rd4, 32'h12345678);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b ready low B", {31'd0, rdy4}, 32'd0);
      chk("b2b valid low B", {31'd0, rv4},  32'd0);
    end
    @(negedge clk);
    chk("b2b resp B valid", {31'd0, rv4}, 32'd1);
    chk("b2b resp B data",  rd4, 32'h00000012);
    chk("b2b resp B err",   {31'd0, er4}, 32'd0);

    // Reset during WAIT drops the load; stored data survives
    @(negedge clk);
    sel = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h40; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("wait before rst", {31'd0, rdy4}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | rv4;
    end
    chk("rst drop resp",   {31'd0, seen}, 32'd0);
    chk("rst ready after", {31'd0, rdy4}, 32'd1);
    req(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h12345678, 0, "L4 ld after rst");

    // Performance counters: 3 loads, 2 stores (one erroneous) after a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("perf rd rst", prc1, 32'd0);
    chk("perf wr rst", pwc1, 32'd0);
    req(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234BEEF, 0, "pc ld w");
    req(0, 0, 2'b00, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0, "pc ld b");
    req(0, 0, 2'b01, 0, 32'h3,  32'h0, 32'h0, 1, "pc ld err");
    req(0, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 32'h0, 0, "pc st w");
    req(0, 1, 2'b10, 0, 32'h31, 32'h0, 32'h0, 1, "pc st err");
`ifdef DMEM_PERF_CNT_EN
    exp_rd = 32'd3;
    exp_wr = 32'd2;
`else
    exp_rd = 32'd0;
    exp_wr = 32'd0;
`endif
    @(negedge clk);
    chk("perf rd cnt", prc1, exp_rd);
    chk("perf wr cnt", pwc1, exp_wr);
    req(0, 0, 2'b10, 0, 32'h30, 32'h0, 32'hCAFEF00D, 0, "pc ld back");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
